spi_ram: RTL and testbench
==========================

SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 Parameter ADDR_SIZE, default 8, SHALL set the address width and the data word width.
REQ-002 Parameter MEM_DEPTH, default 2**ADDR_SIZE, SHALL set the number of memory words.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 rx_valid  input  1  SHALL qualify rx_data from the upstream SPI slave for one cycle.
REQ-006 rx_data  input  ADDR_SIZE+2  SHALL carry the command in bits [ADDR_SIZE+1:ADDR_SIZE] and the payload in bits [ADDR_SIZE-1:0].
REQ-007 tx_valid  output  1  SHALL be a one-cycle strobe marking valid read data toward the SPI slave.
REQ-008 tx_data  output  ADDR_SIZE  SHALL carry the read data word.
REQ-009 cmd_err  output  1  SHALL be a one-cycle strobe flagging a rejected command.

Function
REQ-010 The block SHALL decode a command only on a rising edge where rx_valid=1 and rst=0; all other cycles are idle.
REQ-011 Command 00 (write address) SHALL load payload into wr_addr and set flag wr_addr_vld.
REQ-012 Command 01 (write data) with wr_addr_vld=1 SHALL write payload to mem[wr_addr]; with wr_addr_vld=0 it SHALL write nothing and pulse cmd_err.
REQ-013 Command 10 (read address) SHALL load payload into rd_addr and set flag rd_addr_vld.
REQ-014 Command 11 (read data) with rd_addr_vld=1 SHALL ignore the payload, register mem[rd_addr] into tx_data, and assert tx_valid for exactly the one cycle following the accepting edge.
REQ-015 Command 11 with rd_addr_vld=0 SHALL leave tx_data unchanged, keep tx_valid=0, and pulse cmd_err.
REQ-016 Address flags SHALL stay set until reset. Repeated 01 or 11 commands SHALL reuse the held address, except as modified by REQ-026.
REQ-017 A payload address >= MEM_DEPTH on command 00 or 10 SHALL be rejected: the address is not loaded, the flag is unchanged, and cmd_err pulses.
REQ-018 tx_data SHALL hold its last read value until the next accepted read.
REQ-019 Back-to-back rx_valid on every cycle SHALL be supported with no stall. Consecutive 11 commands SHALL give tx_valid high on consecutive cycles.
REQ-020 A read accepted one or more edges after a write to the same address SHALL return the newly written data.
REQ-021 cmd_err and tx_valid SHALL never be asserted in the same cycle.

Reset
REQ-022 While rst=1, the block SHALL force tx_valid=0, tx_data=0, cmd_err=0, wr_addr=0, rd_addr=0, wr_addr_vld=0, rd_addr_vld=0.
REQ-023 Memory contents SHALL NOT be cleared by reset.
REQ-024 When rst=1 on the edge after a read was accepted, the pending tx_valid SHALL be cancelled.
REQ-025 When rst=1 and rx_valid=1 on the same edge, the command SHALL be discarded.

Configuration
REQ-026 With macro SPI_RAM_AUTOINC_EN defined:
- each accepted 01 command SHALL increment wr_addr after the write;
- each accepted 11 command SHALL increment rd_addr after the read;
- both addresses SHALL wrap from MEM_DEPTH-1 to 0.
Without the macro, wr_addr and rd_addr SHALL change only on 00 and 10 commands respectively.

Verification
REQ-027 Reset: hold rst=1 for 2 cycles -> tx_valid=0, tx_data=0x00, cmd_err=0.
REQ-028 Write/read: rx_data 0x055, 0x1A3, 0x255, 0x300 -> tx_valid high one cycle after 0x300 is accepted, tx_data=0xA3, cmd_err never asserted.
REQ-029 Illegal order after reset: rx_data 0x1FF -> cmd_err pulse and no memory write; rx_data 0x300 -> cmd_err pulse, tx_valid stays 0.
REQ-030 Auto-increment: rx_data 0x0FF, 0x111, 0x122, then read back address 0xFF and 0x00 -> with SPI_RAM_AUTOINC_EN, reads return 0x11 and 0x22; without it, address 0xFF returns 0x22.
REQ-031 Back-to-back: rx_data 0x210 then 0x300, 0x300 on consecutive cycles -> tx_valid high 2 consecutive cycles, both with data of mem[0x10] (non-autoinc build).
REQ-032 Reset mid-read: accept 0x300, assert rst on the next edge -> tx_valid never rises, and a later 0x300 pulses cmd_err.

Source files
------------

// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - SPI command-decoded single-port RAM (optional feature macro: SPI_RAM_AUTOINC_EN)
module spi_ram #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 2**ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [ADDR_SIZE+1:0] rx_data,
  output logic                 tx_valid,
  output logic [ADDR_SIZE-1:0] tx_data,
  output logic                 cmd_err
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload;
  logic                 accept;
  logic                 addr_ok;
  logic                 mem_we;

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_addr_vld_q, wr_addr_vld_d;
  logic                 rd_addr_vld_q, rd_addr_vld_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [ADDR_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 cmd_err_q, cmd_err_d;

  assign cmd     = rx_data[ADDR_SIZE+1:ADDR_SIZE];
  assign payload = rx_data[ADDR_SIZE-1:0];
  // A command arriving on a reset edge is dropped entirely.
  assign accept  = rx_valid && !rst;
  assign addr_ok = int'(payload) < MEM_DEPTH;

  // Command decode: next-state for address registers, flags, read data and strobes.
  always_comb begin
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_vld_d = wr_addr_vld_q;
    rd_addr_vld_d = rd_addr_vld_q;
    tx_valid_d    = 1'b0;
    tx_data_d     = tx_data_q;
    cmd_err_d     = 1'b0;
    mem_we        = 1'b0;
    if (accept) begin
      case (cmd)
        CMD_WR_ADDR: begin
          if (addr_ok) begin
            wr_addr_d     = payload;
            wr_addr_vld_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_WR_DATA: begin
          if (wr_addr_vld_q) begin
            mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            wr_addr_d = (wr_addr_q == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : wr_addr_q + 1'b1;
`else
            wr_addr_d = wr_addr_q;
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          if (addr_ok) begin
            rd_addr_d     = payload;
            rd_addr_vld_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: begin
          if (rd_addr_vld_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = mem[rd_addr_q];
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr_d = (rd_addr_q == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : rd_addr_q + 1'b1;
`else
            rd_addr_d = rd_addr_q;
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Control and output registers with synchronous reset; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_addr_vld_q <= 1'b0;
      rd_addr_vld_q <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_vld_q <= wr_addr_vld_d;
      rd_addr_vld_q <= rd_addr_vld_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= payload;
  end

  // Outputs are forced low as soon as rst is raised, so a read strobe pending
  // into a reset edge never reaches the SPI slave.
  assign tx_valid = tx_valid_q && !rst;
  assign cmd_err  = cmd_err_q && !rst;
  assign tx_data  = rst ? '0 : tx_data_q;

endmodule

// File: tb/tb_spi_ram.sv
// tb/tb_spi_ram.sv - directed self-checking bench for spi_ram
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       cmd_err;

  logic       rx_valid_s;
  logic [9:0] rx_data_s;
  logic       tx_valid_s;
  logic [7:0] tx_data_s;
  logic       cmd_err_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_ram u_dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .cmd_err  (cmd_err)
  );

  // Reduced depth instance for the out-of-range address checks.
  spi_ram #(.ADDR_SIZE(8), .MEM_DEPTH(200)) u_small (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid_s),
    .rx_data  (rx_data_s),
    .tx_valid (tx_valid_s),
    .tx_data  (tx_data_s),
    .cmd_err  (cmd_err_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the main instance starting at a negedge; returns at the
  // next negedge, when the outputs reflect the edge that sampled the inputs.
  task automatic step(input logic v, input logic [9:0] d);
    rx_valid = v;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic step_s(input logic v, input logic [9:0] d);
    rx_valid_s = v;
    rx_data_s  = d;
    @(negedge clk);
    rx_valid_s = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    rx_valid_s = 1'b0;
    rx_data_s  = '0;
    @(negedge clk);

    // Reset held for two cycles
    step(1'b0, 10'h000);
    step(1'b0, 10'h000);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_cmd_err", cmd_err, 1'b0);
    rst = 1'b0;

    // Preload mem[0xFF]=0xAA, then reset: memory must survive
    step(1'b1, 10'h0FF);
    step(1'b1, 10'h1AA);
    check("preload_err", cmd_err, 1'b0);
    rst = 1'b1;
    step(1'b0, 10'h000);
    rst = 1'b0;

    // Illegal order after reset
    step(1'b1, 10'h1FF);
    check("wdata_noaddr_err", cmd_err, 1'b1);
    check("wdata_noaddr_txv", tx_valid, 1'b0);
    step(1'b1, 10'h300);
    check("rdata_noaddr_err", cmd_err, 1'b1);
    check("rdata_noaddr_txv", tx_valid, 1'b0);
    check("rdata_noaddr_txd", tx_data, 8'h00);
    step(1'b1, 10'h2FF);
    check("raddr_err", cmd_err, 1'b0);
    step(1'b1, 10'h300);
    check("mem_kept_txv", tx_valid, 1'b1);
    check("mem_kept_txd", tx_data, 8'hAA);
    check("mem_kept_err", cmd_err, 1'b0);
    step(1'b0, 10'h000);
    check("strobe_one_cycle", tx_valid, 1'b0);

    // Basic write then read
    step(1'b1, 10'h055);
    check("wr_a_err", cmd_err, 1'b0);
    step(1'b1, 10'h1A3);
    check("wr_d_err", cmd_err, 1'b0);
    step(1'b1, 10'h255);
    check("rd_a_err", cmd_err, 1'b0);
    check("rd_a_txv", tx_valid, 1'b0);
    step(1'b1, 10'h300);
    check("rd_txv", tx_valid, 1'b1);
    check("rd_txd", tx_data, 8'hA3);
    check("rd_err", cmd_err, 1'b0);
    step(1'b0, 10'h000);
    check("rd_after_txv", tx_valid, 1'b0);
    check("rd_hold_txd", tx_data, 8'hA3);

    // Repeated writes reuse the held address (non-autoinc build)
    step(1'b1, 10'h0FF);
    step(1'b1, 10'h111);
    step(1'b1, 10'h122);
    step(1'b1, 10'h2FF);
    step(1'b1, 10'h300);
    check("reuse_txv", tx_valid, 1'b1);
    check("reuse_txd", tx_data, 8'h22);

    // Back-to-back reads of mem[0x10]
    step(1'b1, 10'h010);
    step(1'b1, 10'h15C);
    step(1'b1, 10'h210);
    step(1'b1, 10'h300);
    check("b2b_0_txv", tx_valid, 1'b1);
    check("b2b_0_txd", tx_data, 8'h5C);
    step(1'b1, 10'h300);
    check("b2b_1_txv", tx_valid, 1'b1);
    check("b2b_1_txd", tx_data, 8'h5C);
    step(1'b0, 10'h000);
    check("b2b_end_txv", tx_valid, 1'b0);

    // Read on the edge right after a write to the same address
    step(1'b1, 10'h1E1);
    step(1'b1, 10'h300);
    check("raw_txv", tx_valid, 1'b1);
    check("raw_txd", tx_data, 8'hE1);

    // Reset on the edge after an accepted read, with a command discarded
    step(1'b1, 10'h300);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 10'h210;
    #1;
    check("rst_cancel_txv", tx_valid, 1'b0);
    check("rst_force_txd", tx_data, 8'h00);
    @(negedge clk);
    check("rst_hold_txv", tx_valid, 1'b0);
    rst      = 1'b0;
    rx_valid = 1'b0;
    step(1'b1, 10'h300);
    check("post_rst_err", cmd_err, 1'b1);
    check("post_rst_txv", tx_valid, 1'b0);

    // Address range on a 200-word memory
    step_s(1'b1, 10'h2C8);
    check("s_raddr_oob_err", cmd_err_s, 1'b1);
    step_s(1'b1, 10'h300);
    check("s_flag_unchanged_err", cmd_err_s, 1'b1);
    step_s(1'b1, 10'h0C8);
    check("s_waddr_oob_err", cmd_err_s, 1'b1);
    step_s(1'b1, 10'h0C7);
    check("s_waddr_last_err", cmd_err_s, 1'b0);
    step_s(1'b1, 10'h1AB);
    check("s_wdata_err", cmd_err_s, 1'b0);
    step_s(1'b1, 10'h2C7);
    check("s_raddr_last_err", cmd_err_s, 1'b0);
    step_s(1'b1, 10'h3FF);
    check("s_rd_txv", tx_valid_s, 1'b1);
    check("s_rd_txd", tx_data_s, 8'hAB);
    step_s(1'b1, 10'h2FF);
    check("s_oob_keep_err", cmd_err_s, 1'b1);
    step_s(1'b1, 10'h300);
    check("s_oob_keep_txd", tx_data_s, 8'hAB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
